// File: rtl/xrv_pkg.sv
// ---------------------------------------------------------------------------
// xrv_pkg
// Shared encodings for the XRV M-extension arithmetic blocks.
//   - Divider operation types (funct3[1:0]): DIV, DIVU, REM, REMU
//   - Multiplier operation types (funct3[1:0]): MUL, MULH, MULHSU, MULHU
//   - Divider FSM state constants
//   - Small helpers for decoding the divider operation type
// No ports; imported by the datapath blocks.
// ---------------------------------------------------------------------------
package xrv_pkg;

  // Divider operation types, taken straight from funct3[1:0]
  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  // Multiplier operation types, taken straight from funct3[1:0]
  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  // Divider FSM states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_SIGN = 2'b10;

  // Most negative 32-bit value and all-ones, used by the special cases
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Bit 0 of the divider type is clear for the signed flavours
  function automatic logic div_is_signed(input logic [1:0] t);
    return ~t[0];
  endfunction

  // Bit 1 of the divider type selects remainder over quotient
  function automatic logic div_is_rem(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/xrv_div.sv
// ---------------------------------------------------------------------------
// xrv_div
// Iterative 32-bit RISC-V divider (DIV/DIVU/REM/REMU), restoring algorithm,
// one quotient bit per cycle.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rstb         in   1   asynchronous active-low reset
//   a            in   32  dividend (rs1)
//   b            in   32  divisor (rs2)
//   div_type     in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   valid        in   1   start request; a, b, div_type sampled with it
//   busy         out  1   high while an operation is in progress
//   result       out  32  quotient or remainder per div_type
//   result_valid out  1   single-cycle pulse when result is new
//
// Divide-by-zero and signed overflow complete on the sampling edge without
// leaving IDLE. Everything else takes IDLE -> 32 x CALC -> SIGN -> IDLE,
// with result_valid visible after the 34th edge.
// ---------------------------------------------------------------------------
module xrv_div
  import xrv_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  div_type,
  input  logic        valid,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid
);

  logic [1:0]  state;
  logic [4:0]  count;

  // Datapath: dividend register doubles as the quotient shift register
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] prem;
  logic        q_neg;
  logic        r_neg;
  logic [1:0]  op_type;

  // Decode of the incoming request, only meaningful while in IDLE
  logic        in_signed;
  logic        in_rem;
  logic        div_zero;
  logic        overflow;

  assign in_signed = div_is_signed(div_type);
  assign in_rem    = div_is_rem(div_type);
  assign div_zero  = (b == 32'd0);
  assign overflow  = in_signed && (a == INT_MIN) && (b == ALL_ONES);

  // One restoring step: the partial remainder shifted left with the next
  // dividend bit appended is 33 bits wide, and the single subtractor's
  // borrow (bit 32) says whether the divisor fits.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  assign shifted = {1'b0, prem, dividend[31]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = ~diff[32];

  // Final sign fix-up: pick quotient or remainder, then negate when the
  // applicable sign is set for a signed operation.
  logic [31:0] raw_out;
  logic        do_negate;
  logic [31:0] fixed_out;

  assign raw_out   = div_is_rem(op_type) ? prem : dividend;
  assign do_negate = div_is_signed(op_type) && (div_is_rem(op_type) ? r_neg : q_neg);
  assign fixed_out = do_negate ? (~raw_out + 32'd1) : raw_out;

  assign busy = (state != ST_IDLE);

  // Control and output registers. result_valid defaults low every cycle so
  // it can only ever be a one-cycle pulse; valid outside IDLE is ignored.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= ST_IDLE;
      count        <= 5'd0;
      result       <= 32'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            if (div_zero) begin
              result       <= in_rem ? a : ALL_ONES;
              result_valid <= 1'b1;
            end else if (overflow) begin
              result       <= in_rem ? 32'd0 : INT_MIN;
              result_valid <= 1'b1;
            end else begin
              count <= 5'd31;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          count <= count - 5'd1;
          if (count == 5'd0) begin
            state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          result       <= fixed_out;
          result_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers carry no reset: they are always reloaded on an
  // accepted request before anything reaches the outputs. Loading them on
  // a special-case request is harmless since the FSM stays in IDLE.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (valid) begin
          dividend <= (in_signed && a[31]) ? (~a + 32'd1) : a;
          divisor  <= (in_signed && b[31]) ? (~b + 32'd1) : b;
          q_neg    <= a[31] ^ b[31];
          r_neg    <= a[31];
          op_type  <= div_type;
          prem     <= 32'd0;
        end
      end
      ST_CALC: begin
        prem     <= fits ? diff[31:0] : shifted[31:0];
        dividend <= {dividend[30:0], fits};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/xrv_div.md
XRV_DIV -- requirements
Module: xrv_div

Interface
REQ-001 SHALL have port clk, input, 1, clock; all flops rise-edge.
REQ-002 SHALL have port rstb, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port a, input, 32, dividend (rs1).
REQ-004 SHALL have port b, input, 32, divisor (rs2).
REQ-005 SHALL have port div_type, input, 2, funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port valid, input, 1, start request; operands and div_type sampled with it.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port result, output, 32, quotient or remainder per div_type.
REQ-009 SHALL have port result_valid, output, 1, single-cycle pulse marking result as new.

Function
REQ-010 SHALL implement states IDLE, CALC, SIGN; busy = (state != IDLE).
REQ-011 SHALL accept valid only in IDLE; valid while busy SHALL be ignored, with no queuing and no effect on the current operation.
REQ-012 SHALL, in IDLE with valid, b==0, on the same edge set result to 0xFFFFFFFF (DIV/DIVU) or a (REM/REMU), pulse result_valid and stay IDLE; latency 1.
REQ-013 SHALL, in IDLE with valid, signed type, a==0x80000000 and b==0xFFFFFFFF, set result to 0x80000000 (DIV) or 0 (REM), pulse result_valid and stay IDLE; latency 1.
REQ-014 SHALL otherwise latch |a|, |b| (signed types) or a, b (unsigned types), the quotient sign (a[31]^b[31]), the remainder sign (a[31]) and div_type, clear the partial remainder, load a 5-bit counter with 31 and enter CALC.
REQ-015 SHALL, per CALC cycle, perform one restoring step:
- shift the 33-bit partial remainder left, taking in the dividend MSB;
- trial-subtract the divisor;
- if non-negative, keep the difference and shift in quotient bit 1, else shift in 0.
REQ-016 SHALL leave CALC for SIGN when the counter equals 0, giving exactly 32 CALC cycles.
REQ-017 SHALL, in SIGN, register the result, negated (two's complement) if the applicable sign is set for a signed type, pulse result_valid for one cycle and return to IDLE.
REQ-018 SHALL give a normal-path latency of 34 edges: the valid-sampling edge, then result_valid high in the cycle after the 34th edge.
REQ-019 SHALL hold result stable between result_valid pulses.
REQ-020 SHALL keep result_valid low in every cycle except the completion cycle.
REQ-021 SHALL produce a remainder whose sign follows the dividend and that satisfies a == q*b + r (mod 2^32) for all non-special inputs.
REQ-022 SHALL allow a new valid in the cycle in which result_valid is high, since the block is then in IDLE; back-to-back operations SHALL NOT be lost.

Reset
REQ-023 SHALL, with rstb low, force state=IDLE, busy=0, result_valid=0, result=0 and counter=0, asynchronously.
REQ-024 SHALL abort any operation in flight on a mid-operation reset, with no result_valid pulse produced after rstb deasserts.
REQ-025 Datapath registers (operands, partial remainder) MAY be non-reset but SHALL NOT affect outputs before the first accepted valid.

Structure
REQ-026 SHALL place div_type encodings (DIV, DIVU, REM, REMU) and the state enum in shared package xrv_pkg, alongside the multiplier type encodings.
REQ-027 SHALL be a single module with no sub-module; the step logic is one subtractor and a mux.
REQ-028 SHALL use one 33-bit subtractor, with no combinational path from a, b or valid to any output.

Verification
REQ-029 DIV a=20, b=0xFFFFFFFD -> result 0xFFFFFFFA with result_valid 34 edges after valid; REM with the same operands -> 0x00000002.
REQ-030 DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; REMU -> 0x00000001; REM a=0xFFFFFFF9, b=2 -> 0xFFFFFFFF.
REQ-031 DIV a=7, b=0 -> 0xFFFFFFFF and REM -> 0x00000007, each with result_valid 1 edge after valid and busy never high.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; latency 1; DIVU with the same operands -> 0x00000000 via the 34-edge path.
REQ-033 Second valid asserted at CALC cycle 5 -> ignored, exactly one result_valid pulse, first result unchanged; new valid during the result_valid cycle -> accepted.
REQ-034 rstb low at CALC cycle 10 -> busy, result_valid and result all 0 immediately; no pulse within 40 cycles after release; next operation correct.
